// File: rtl/beat_pkg.sv
// beat_pkg: shared types and constants for the beat detector slice.
//   beat_state_t : detector FSM states (SEED, WARMUP, ARMED, HOLDOFF)
//   ENV_WIDTH    : width of the brightness envelope
//   ENV_MAX      : envelope value loaded on a beat
//   CMP_EXTRA    : guard bits for the ratio compare (mag*4 vs avg*THRESH_Q2)
package beat_pkg;

    typedef enum logic [1:0] {
        SEED,
        WARMUP,
        ARMED,
        HOLDOFF
    } beat_state_t;

    localparam int unsigned ENV_WIDTH = 8;
    localparam logic [ENV_WIDTH-1:0] ENV_MAX = 8'hFF;
    localparam int unsigned CMP_EXTRA = 4;

endpackage

// File: rtl/beat_detector_ema_tracker.sv
// ema_tracker: long-term exponential moving average of the magnitude stream.
//   clk, rst : clock, synchronous active-high reset (clears the accumulator)
//   seed     : load acc with mag_in << AVG_SHIFT (first sample after reset)
//   update   : acc <= acc - avg + mag_in
//   mag_in   : input magnitude
//   avg      : acc >> AVG_SHIFT, combinational from the accumulator
// The accumulator carries AVG_SHIFT extra bits, so acc never exceeds
// (2^WIDTH-1) << AVG_SHIFT and the update cannot overflow.
module ema_tracker
    import beat_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned AVG_SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed,
    input  logic             update,
    input  logic [WIDTH-1:0] mag_in,
    output logic [WIDTH-1:0] avg
);

    localparam int unsigned ACC_W = WIDTH + AVG_SHIFT;

    logic [ACC_W-1:0] acc;

    assign avg = acc[ACC_W-1:AVG_SHIFT];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (seed) begin
            acc <= ACC_W'(mag_in) << AVG_SHIFT;
        end else if (update) begin
            acc <= acc - ACC_W'(avg) + ACC_W'(mag_in);
        end
    end

endmodule

// File: rtl/beat_detector.sv
// beat_detector: flags onsets in the smoothed magnitude stream and produces a
// decaying 8-bit brightness envelope.
//   clk, rst     : clock, synchronous active-high reset
//   mag_in       : smoothed magnitude, qualified by mag_in_valid
//   beat_pulse   : one-cycle pulse, the cycle after a beat-triggering sample
//   env_level    : brightness envelope (255 on beat, geometric decay to 0)
//   avg_out      : current long-term average
//   out_valid    : one-cycle pulse after every accepted sample
//   armed        : high while the detector is able to fire
//   beat_count   : saturating beat counter (only with BEAT_DETECTOR_STATS_EN)
// Optional build macro: BEAT_DETECTOR_STATS_EN adds the beat_count port.
module beat_detector
    import beat_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned AVG_SHIFT       = 6,
    parameter int unsigned THRESH_Q2       = 6,
    parameter int unsigned MIN_LEVEL       = 1024,
    parameter int unsigned HOLDOFF_SAMPLES = 8,
    parameter int unsigned ENV_DECAY_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     mag_in,
    input  logic                 mag_in_valid,
    output logic                 beat_pulse,
    output logic [ENV_WIDTH-1:0] env_level,
    output logic [WIDTH-1:0]     avg_out,
`ifdef BEAT_DETECTOR_STATS_EN
    output logic [15:0]          beat_count,
`endif
    output logic                 out_valid,
    output logic                 armed
);

    localparam int unsigned CMP_W  = WIDTH + CMP_EXTRA;
    localparam int unsigned WARM_W = AVG_SHIFT + 1;
    localparam int unsigned HOLD_W = $clog2(HOLDOFF_SAMPLES + 1);

    beat_state_t          state;
    logic [WARM_W-1:0]    warm_cnt;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [ENV_WIDTH-1:0] env;
    logic [WIDTH-1:0]     avg;
    logic                 seed;
    logic                 update;
    logic [CMP_W-1:0]     mag_x4;
    logic [CMP_W-1:0]     avg_xt;
    logic                 beat_hit;
    logic [ENV_WIDTH-1:0] env_step;
    logic [ENV_WIDTH-1:0] env_next;

    assign seed   = mag_in_valid && (state == SEED);
    assign update = mag_in_valid && (state != SEED);

    ema_tracker #(
        .WIDTH    (WIDTH),
        .AVG_SHIFT(AVG_SHIFT)
    ) u_ema (
        .clk   (clk),
        .rst   (rst),
        .seed  (seed),
        .update(update),
        .mag_in(mag_in),
        .avg   (avg)
    );

    assign avg_out   = avg;
    assign env_level = env;

    // Ratio test uses the average from before this sample's update; both
    // products are widened so all-ones inputs cannot wrap.
    always_comb begin
        mag_x4   = CMP_W'(mag_in) << 2;
        avg_xt   = CMP_W'(avg) * CMP_W'(THRESH_Q2);
        beat_hit = (state == ARMED) && (mag_in >= WIDTH'(MIN_LEVEL)) && (mag_x4 > avg_xt);
    end

    // Decay by at least 1 so small envelopes still reach 0 without underflow.
    always_comb begin
        env_step = env >> ENV_DECAY_SHIFT;
        if (env_step == '0) begin
            env_step = ENV_WIDTH'(1);
        end
        env_next = (env == '0) ? '0 : env - env_step;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEED;
            warm_cnt   <= '0;
            hold_cnt   <= '0;
            env        <= '0;
            beat_pulse <= 1'b0;
            out_valid  <= 1'b0;
            armed      <= 1'b0;
        end else begin
            beat_pulse <= 1'b0;
            out_valid  <= 1'b0;
            if (mag_in_valid) begin
                out_valid <= 1'b1;
                env       <= beat_hit ? ENV_MAX : env_next;
                case (state)
                    SEED: begin
                        warm_cnt <= WARM_W'(2 ** AVG_SHIFT);
                        state    <= WARMUP;
                    end
                    WARMUP: begin
                        warm_cnt <= warm_cnt - WARM_W'(1);
                        if (warm_cnt == WARM_W'(1)) begin
                            state <= ARMED;
                            armed <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (beat_hit) begin
                            beat_pulse <= 1'b1;
                            hold_cnt   <= HOLD_W'(HOLDOFF_SAMPLES);
                            state      <= HOLDOFF;
                            armed      <= 1'b0;
                        end
                    end
                    HOLDOFF: begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                        if (hold_cnt == HOLD_W'(1)) begin
                            state <= ARMED;
                            armed <= 1'b1;
                        end
                    end
                    default: state <= SEED;
                endcase
            end
        end
    end

`ifdef BEAT_DETECTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count <= '0;
        end else if (mag_in_valid && beat_hit && (beat_count != '1)) begin
            beat_count <= beat_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/beat_detector.md
Name: beat_detector

Overview:
Consumes the smoothed magnitude stream from the magnitude smoother and flags onsets (beats) for the lighting FSM. It tracks a long-term exponential average of the input and declares a beat when the current sample exceeds that average by a programmable ratio. A refractory hold-off follows each beat. It also produces an 8-bit decaying envelope, which drives LED brightness directly.

Parameters:
WIDTH, 32, magnitude width; must match the smoother output.
AVG_SHIFT, 6, EMA factor is 1/2^AVG_SHIFT; warm-up length is 2^AVG_SHIFT samples.
THRESH_Q2, 6, beat ratio in Q2.2 (6 = 1.5x); legal range 1..15.
MIN_LEVEL, 1024, samples below this never trigger a beat (silence gate).
HOLDOFF_SAMPLES, 8, number of valid samples ignored after a beat; minimum 1.
ENV_DECAY_SHIFT, 3, envelope loses env>>ENV_DECAY_SHIFT per valid sample.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mag_in  in  WIDTH  smoothed magnitude
mag_in_valid  in  1  qualifies mag_in; no backpressure
beat_pulse  out  1  one-cycle pulse per detected beat
env_level  out  8  decaying brightness envelope
avg_out  out  WIDTH  current long-term average (acc >> AVG_SHIFT)
out_valid  out  1  one-cycle pulse; env_level and avg_out updated
armed  out  1  high while state == ARMED

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0; acc=0; counters 0; state SEED. Reset mid-operation aborts hold-off and warm-up immediately.
- Latency: all registers update on the edge where mag_in_valid=1. beat_pulse and out_valid are high the following cycle, for exactly one cycle. Cycles without valid hold every register, with beat_pulse=0 and out_valid=0.
- Accumulator width is WIDTH+AVG_SHIFT. avg = acc >> AVG_SHIFT.
- States: SEED, WARMUP, ARMED, HOLDOFF.
- SEED, first valid: acc <= mag_in << AVG_SHIFT; warm_cnt <= 2^AVG_SHIFT; go to WARMUP. No beat.
- Every later valid: acc <= acc - avg + mag_in. The beat test always uses avg from before this update.
- WARMUP: decrement warm_cnt per valid. When the valid arrives with warm_cnt==1, go to ARMED. No beat in WARMUP.
- ARMED, beat condition: mag_in >= MIN_LEVEL AND (mag_in*4) > (avg*THRESH_Q2). Compare at WIDTH+4 bits with no truncation; strictly greater.
- ARMED, on beat: beat_pulse next cycle; hold_cnt <= HOLDOFF_SAMPLES; go to HOLDOFF.
- HOLDOFF: each valid decrements hold_cnt; no beat is possible. The valid arriving with hold_cnt==1 returns to ARMED, so exactly HOLDOFF_SAMPLES samples are ignored.
- Envelope, on beat: env <= 255.
- Envelope, otherwise per valid: env <= env - max(env>>ENV_DECAY_SHIFT, 1) when env != 0, so it reaches 0 and never underflows. It stays 0 when already 0.
- mag_in=0 or all-ones must neither overflow acc nor the comparison.

Optional Feature:
BEAT_DETECTOR_STATS_EN
- Defined: adds output beat_count (16 bits), a saturating count of beats since reset. Reset value 0; holds at 16'hFFFF.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package beat_pkg holds:
  - typedef enum beat_state_t {SEED, WARMUP, ARMED, HOLDOFF};
  - localparam ENV_WIDTH=8 and ENV_MAX=8'hFF;
  - localparam CMP_EXTRA=4, the guard bits for the ratio compare.
- One sub-module, ema_tracker (params WIDTH, AVG_SHIFT), owns:
  - the accumulator and seed load, via seed/update inputs;
  - avg output, combinational from acc.
- The FSM, comparator and envelope stay in beat_detector.

Test Plan:
All scenarios use WIDTH=32, AVG_SHIFT=2, THRESH_Q2=6, MIN_LEVEL=1024, HOLDOFF_SAMPLES=3, ENV_DECAY_SHIFT=3 unless stated.
1. Steady level: 10 valids of 1000 (MIN_LEVEL=0) -> no beat_pulse; avg_out=1000 after the first; armed rises after the 5th valid (seed + 4 warm-up).
2. Beat: after scenario 1, one valid of 2000 -> beat_pulse one cycle later (8000 > 6000); env_level=255; avg_out=1250.
3. Hold-off: follow with 2000 x4 -> samples 1-3 give no beat, avg_out 1437/1578/1683; armed returns after the 3rd. The 4th gives no beat (8000 <= 1683*6=10098).
4. Envelope decay: after a beat, feed quiet valids -> env_level 224, 196, 172; it must reach exactly 0 and stay 0.
5. Silence gate: avg=100, spike of 1000 < MIN_LEVEL -> no beat. A spike of 2000 -> beat.
6. Reset mid-HOLDOFF: assert rst for 1 cycle -> all outputs 0, armed=0, state SEED. The next valid re-seeds acc, and the warm-up count restarts at 4.
